// File: rtl/m_rf_sb_if.sv
// m_rf_sb_if: read, writeback and issue bundle for the scoreboarded register file
interface m_rf_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   w_rs1, w_rs2, w_waddr, w_issue_rd;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_wdata;
  logic            w_we, w_issue, w_rs1_busy, w_rs2_busy, w_stall, w_halt;
  logic [31:0]     w_wr_count;
  modport master (
    output w_rs1, w_rs2, w_we, w_waddr, w_wdata, w_issue, w_issue_rd,
    input  w_rs1_val, w_rs2_val, w_rs1_busy, w_rs2_busy, w_stall, w_halt, w_wr_count
  );
  modport slave (
    input  w_rs1, w_rs2, w_we, w_waddr, w_wdata, w_issue, w_issue_rd,
    output w_rs1_val, w_rs2_val, w_rs1_busy, w_rs2_busy, w_stall, w_halt, w_wr_count
  );
endinterface

// File: rtl/m_rf_sb.sv
// m_rf_sb: register file with write bypass, busy scoreboard and sticky halt
module m_rf_sb #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int HALT_EN  = 1,
  parameter int HALT_REG = 30
) (
  input logic       w_clk,
  input logic       w_rst_n,
  m_rf_sb_if.slave  rf
);
  localparam int NREG = 2**AW;
  localparam logic [AW-1:0] HALT_ADDR = AW'(HALT_REG);
  logic [XLEN-1:0] r_mem [NREG];
  logic [NREG-1:0] r_busy;
  logic            r_halt;
  logic [31:0]     r_wr_count;
  logic            w_commit, w_byp, w_rd_busy, w_accept;
  // reset gating keeps the bypass path quiet while reset is held
  assign w_commit = w_rst_n & rf.w_we & (rf.w_waddr != '0) & ~r_halt;
  assign w_byp    = (BYPASS != 0) & w_commit;
  // reads: x0 is hardwired, a same-cycle commit is forwarded when bypass is on
  always_comb begin
    rf.w_rs1_val  = (rf.w_rs1 == '0) ? '0 : (w_byp && rf.w_waddr == rf.w_rs1) ? rf.w_wdata : r_mem[rf.w_rs1];
    rf.w_rs2_val  = (rf.w_rs2 == '0) ? '0 : (w_byp && rf.w_waddr == rf.w_rs2) ? rf.w_wdata : r_mem[rf.w_rs2];
    rf.w_rs1_busy = r_busy[rf.w_rs1] & ~(w_byp & (rf.w_waddr == rf.w_rs1));
    rf.w_rs2_busy = r_busy[rf.w_rs2] & ~(w_byp & (rf.w_waddr == rf.w_rs2));
    w_rd_busy     = r_busy[rf.w_issue_rd] & ~(w_byp & (rf.w_waddr == rf.w_issue_rd));
    rf.w_stall    = r_halt | (rf.w_issue & (rf.w_rs1_busy | rf.w_rs2_busy | w_rd_busy));
    w_accept      = rf.w_issue & ~rf.w_stall & (rf.w_issue_rd != '0);
  end
  assign rf.w_halt     = r_halt;
  assign rf.w_wr_count = r_wr_count;
  // register array, commit counter and halt latch on a write to HALT_REG
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      r_halt     <= 1'b0;
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_mem[rf.w_waddr] <= rf.w_wdata;
      r_wr_count        <= r_wr_count + 32'd1;
      if (HALT_EN != 0 && rf.w_waddr == HALT_ADDR) r_halt <= 1'b1;
    end
  // scoreboard: commit clears, accepted issue sets last so a new producer wins
  always_ff @(posedge w_clk or negedge w_rst_n)
    if (!w_rst_n) r_busy <= '0;
    else begin
      if (w_commit) r_busy[rf.w_waddr] <= 1'b0;
      if (w_accept) r_busy[rf.w_issue_rd] <= 1'b1;
    end
endmodule
